// File: rtl/seq_detect_ctrl_if.sv
// Configuration handshake bundle for seq_detect_ctrl.
// The master offers a pattern, length, target and overlap mode; the slave accepts on cfg_ready.
interface seq_detect_ctrl_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 3,
    parameter int unsigned CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_overlap;

    modport master (
        output cfg_valid,
        output cfg_pattern,
        output cfg_len,
        output cfg_target,
        output cfg_overlap,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_pattern,
        input  cfg_len,
        input  cfg_target,
        input  cfg_overlap,
        output cfg_ready
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run-time configurable serial pattern-detect controller.
// Latches a pattern in IDLE, scans qualified serial bits in RUN and counts Mealy matches
// until a target count (DONE) or abort. Optional idle timeout is enabled by defining
// SEQDET_TIMEOUT_EN; without it timeout is tied low and RUN waits indefinitely.
module seq_detect_ctrl #(
    parameter int unsigned PAT_W  = 8,
    parameter int unsigned LEN_W  = 3,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned TO_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    seq_detect_ctrl_if.slave cfg_if,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Largest usable length-minus-one; also the fill saturation point.
    localparam logic [LEN_W-1:0] FillMax = LEN_W'(PAT_W - 1);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] lm1_q, lm1_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             done_q, done_d;

`ifdef SEQDET_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TO_CYC + 1);
    logic [IdleW-1:0] idle_q, idle_d;
    logic             to_q, to_d;
`else
    logic unused_to_cyc;
    assign unused_to_cyc = (TO_CYC == 0);
`endif

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] len_clamped;
    logic             pat_hit;
    logic             filled;

    // Compare the newest L bits (history plus the current bit) against the pattern.
    always_comb begin
        window = {hist_q, in_bit};
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i <= int'(lm1_q));
        end
        pat_hit = (((window ^ pat_q) & len_mask) == '0);
        filled  = (fill_q >= lm1_q);
        match   = (state_q == StRun) && in_valid && !abort && filled && pat_hit;
    end

    // Lengths beyond PAT_W collapse to the full width.
    always_comb begin
        if (32'(cfg_if.cfg_len) > PAT_W - 1) begin
            len_clamped = FillMax;
        end else begin
            len_clamped = cfg_if.cfg_len;
        end
    end

    // Next-state logic for the controller, counters and registered pulses.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        lm1_d     = lm1_q;
        target_d  = target_q;
        overlap_d = overlap_q;
        count_d   = count_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        done_d    = 1'b0;
`ifdef SEQDET_TIMEOUT_EN
        idle_d    = idle_q;
        to_d      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // A config handshake wins over a coincident start.
                if (cfg_if.cfg_valid) begin
                    pat_d     = cfg_if.cfg_pattern;
                    lm1_d     = len_clamped;
                    target_d  = cfg_if.cfg_target;
                    overlap_d = cfg_if.cfg_overlap;
                end else if (start) begin
                    state_d = StRun;
                    count_d = '0;
                    hist_d  = '0;
                    fill_d  = '0;
`ifdef SEQDET_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (in_valid) begin
                    hist_d = window[PAT_W-2:0];
                    if (fill_q != FillMax) begin
                        fill_d = fill_q + LEN_W'(1);
                    end
`ifdef SEQDET_TIMEOUT_EN
                    idle_d = '0;
`endif
                    if (match) begin
                        if (count_q != '1) begin
                            count_d = count_q + CNT_W'(1);
                        end
                        // Non-overlapping mode needs L fresh bits for the next match.
                        if (!overlap_q) begin
                            hist_d = '0;
                            fill_d = '0;
                        end
                        if ((target_q != '0) && (count_q == target_q - CNT_W'(1))) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end
                end
`ifdef SEQDET_TIMEOUT_EN
                else if (idle_q == IdleW'(TO_CYC - 1)) begin
                    state_d = StIdle;
                    to_d    = 1'b1;
                end else begin
                    idle_d = idle_q + IdleW'(1);
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            lm1_q     <= '0;
            target_q  <= '0;
            overlap_q <= 1'b0;
            count_q   <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            done_q    <= 1'b0;
`ifdef SEQDET_TIMEOUT_EN
            idle_q    <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            lm1_q     <= lm1_d;
            target_q  <= target_d;
            overlap_q <= overlap_d;
            count_q   <= count_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            done_q    <= done_d;
`ifdef SEQDET_TIMEOUT_EN
            idle_q    <= idle_d;
            to_q      <= to_d;
`endif
        end
    end

    assign cfg_if.cfg_ready = (state_q == StIdle);
    assign busy             = (state_q == StRun);
    assign done             = done_q;
    assign match_count      = count_q;
`ifdef SEQDET_TIMEOUT_EN
    assign timeout          = to_q;
`else
    assign timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a bit-queue reference model, a per-cycle compare
// process, directed scenarios with literal expectations and randomized traffic.
module tb_seq_detect_ctrl;
    localparam int unsigned PAT_W  = 6;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TO_CYC = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic match, busy, done, timeout;
    logic [CNT_W-1:0] match_count;

    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) cfg_if ();

    seq_detect_ctrl #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W),
        .TO_CYC(TO_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_if     (cfg_if),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .match      (match),
        .match_count(match_count),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits seen since arming (or since the last non-overlap match).
    bit               m_run, m_fin, m_to, m_ovl;
    int               m_count, m_len, m_target, m_idle, sb_hits;
    logic [PAT_W-1:0] m_pat;
    bit               m_bits[$];

    function automatic bit exp_match();
        bit b;
        if (!m_run || !in_valid || abort) return 1'b0;
        if (m_bits.size() < m_len - 1) return 1'b0;
        for (int j = 0; j < m_len; j++) begin
            b = (j == 0) ? in_bit : m_bits[m_bits.size() - j];
            if (b != m_pat[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_fin = 0; m_to = 0; m_ovl = 0;
        m_count = 0; m_len = 1; m_target = 0; m_idle = 0;
        m_pat = '0;
        m_bits.delete();
    endtask

    task automatic model_step();
        bit hit;
        m_to = 0;
        if (m_fin) begin
            m_fin = 0;
        end else if (!m_run) begin
            if (cfg_if.cfg_valid) begin
                m_pat    = cfg_if.cfg_pattern;
                m_len    = (int'(cfg_if.cfg_len) + 1 > PAT_W) ? PAT_W : int'(cfg_if.cfg_len) + 1;
                m_target = int'(cfg_if.cfg_target);
                m_ovl    = cfg_if.cfg_overlap;
            end else if (start) begin
                m_run = 1; m_count = 0; m_idle = 0;
                m_bits.delete();
            end
        end else if (abort) begin
            m_run = 0;
        end else if (in_valid) begin
            hit = exp_match();
            m_idle = 0;
            m_bits.push_back(in_bit);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            if (hit) begin
                sb_hits++;
                if (m_count < (1 << CNT_W) - 1) m_count++;
                if (!m_ovl) m_bits.delete();
                if (m_target != 0 && m_count == m_target) begin
                    m_run = 0;
                    m_fin = 1;
                end
            end
        end else begin
`ifdef SEQDET_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO_CYC) begin
                m_run = 0;
                m_to = 1;
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        chk("cmp_match", match, exp_match());
        chk("cmp_busy", busy, m_run);
        chk("cmp_done", done, m_fin);
        chk("cmp_timeout", timeout, m_to);
        chk("cmp_cfg_ready", cfg_if.cfg_ready, !(m_run || m_fin));
        chk("cmp_count", match_count, m_count);
    end

    task automatic setcfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic [CNT_W-1:0] tgt, input logic ovl);
        cfg_if.cfg_pattern = pat;
        cfg_if.cfg_len     = len;
        cfg_if.cfg_target  = tgt;
        cfg_if.cfg_overlap = ovl;
    endtask

    // One clock cycle of stimulus; returns match as seen mid-cycle.
    task automatic cyc(input logic cv, input logic st, input logic ab, input logic iv,
                       input logic ib, output logic m);
        cfg_if.cfg_valid = cv;
        start = st; abort = ab; in_valid = iv; in_bit = ib;
        @(negedge clk);
        m = match;
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    endtask

    logic m;
    logic bits_a[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic exp_a[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_b[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic bits_c[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        cfg_if.cfg_valid = 1'b0;
        setcfg('0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", cfg_if.cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", match_count, 0);

        // Overlapping 2'b11, target 3.
        setcfg(6'b000011, 3'd1, 8'd3, 1'b1);
        cyc(1, 0, 0, 0, 0, m);
        cyc(0, 1, 0, 0, 0, m);
        chk("a_busy", busy, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 1, bits_a[i], m);
            chk($sformatf("a_match_bit%0d", i + 1), m, exp_a[i]);
        end
        chk("a_done", done, 1);
        chk("a_count", match_count, 3);
        cyc(0, 0, 0, 0, 0, m);
        chk("a_ready_after", cfg_if.cfg_ready, 1);
        chk("a_done_clear", done, 0);

        // Non-overlapping, same stream: only bits 3 and 7.
        setcfg(6'b000011, 3'd1, 8'd3, 1'b0);
        cyc(1, 0, 0, 0, 0, m);
        cyc(0, 1, 0, 0, 0, m);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 1, bits_a[i], m);
            chk($sformatf("b_match_bit%0d", i + 1), m, exp_b[i]);
        end
        chk("b_busy", busy, 1);
        chk("b_count", match_count, 2);
        cyc(0, 0, 1, 0, 0, m);
        chk("b_abort_busy", busy, 0);
        chk("b_abort_count", match_count, 2);

        // Abort coinciding with the final match.
        setcfg(6'b000011, 3'd1, 8'd2, 1'b1);
        cyc(1, 0, 0, 0, 0, m);
        cyc(0, 1, 0, 0, 0, m);
        cyc(0, 0, 0, 1, 1, m);
        cyc(0, 0, 0, 1, 1, m);
        chk("c_first", m, 1);
        cyc(0, 0, 1, 1, 1, m);
        chk("c_abort_match", m, 0);
        chk("c_busy", busy, 0);
        chk("c_done", done, 0);
        chk("c_count", match_count, 1);

        // Config and start in the same cycle: config only.
        setcfg(6'b000010, 3'd1, 8'd0, 1'b1);
        cyc(1, 1, 0, 0, 0, m);
        chk("d_stay_idle", busy, 0);
        cyc(0, 1, 0, 0, 0, m);
        chk("d_run", busy, 1);
        cyc(0, 0, 0, 1, 1, m);
        chk("d_bit1", m, 0);
        cyc(0, 0, 0, 1, 0, m);
        chk("d_bit2", m, 1);
        cyc(0, 0, 1, 0, 0, m);

        // Clamped length: cfg_len 7 behaves as 6 bits.
        setcfg(6'b101101, 3'd7, 8'd0, 1'b1);
        cyc(1, 0, 0, 0, 0, m);
        cyc(0, 1, 0, 0, 0, m);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, bits_c[i], m);
            chk($sformatf("clamp_bit%0d", i + 1), m, (i == 5) ? 1 : 0);
        end
        cyc(0, 0, 1, 0, 0, m);

        // Free-run 4'b1011 with gaps; counter against the scoreboard.
        setcfg(6'b001011, 3'd3, 8'd0, 1'b1);
        cyc(1, 0, 0, 0, 0, m);
        sb_hits = 0;
        cyc(0, 1, 0, 0, 0, m);
        for (int n = 0; n < 200; ) begin
            logic iv;
            iv = ($urandom_range(3, 0) != 0);
            cyc(0, 0, 0, iv, 1'($urandom_range(1, 0)), m);
            if (iv) n++;
        end
        chk("e_count_vs_sb", match_count, sb_hits);
        chk("e_busy", busy, 1);
        cyc(0, 0, 1, 0, 0, m);

        // Counter saturation in free-run.
        setcfg(6'b000001, 3'd0, 8'd0, 1'b0);
        cyc(1, 0, 0, 0, 0, m);
        cyc(0, 1, 0, 0, 0, m);
        repeat (270) cyc(0, 0, 0, 1, 1, m);
        chk("sat_count", match_count, 255);
        cyc(0, 0, 1, 0, 0, m);

`ifdef SEQDET_TIMEOUT_EN
        setcfg(6'b000011, 3'd1, 8'd0, 1'b1);
        cyc(1, 0, 0, 0, 0, m);
        cyc(0, 1, 0, 0, 0, m);
        repeat (TO_CYC - 1) cyc(0, 0, 0, 0, 0, m);
        chk("to_not_yet", timeout, 0);
        chk("to_still_busy", busy, 1);
        cyc(0, 0, 0, 0, 0, m);
        chk("to_pulse", timeout, 1);
        chk("to_idle", busy, 0);
        cyc(0, 0, 0, 0, 0, m);
        chk("to_pulse_end", timeout, 0);
        cyc(0, 1, 0, 0, 0, m);
        repeat (TO_CYC - 1) cyc(0, 0, 0, 0, 0, m);
        cyc(0, 0, 0, 1, 0, m);
        chk("to_rescued_busy", busy, 1);
        chk("to_rescued_flag", timeout, 0);
        cyc(0, 0, 1, 0, 0, m);
`endif

        // Asynchronous reset in the middle of RUN.
        setcfg(6'b000001, 3'd0, 8'd0, 1'b1);
        cyc(1, 0, 0, 0, 0, m);
        cyc(0, 1, 0, 0, 0, m);
        repeat (3) cyc(0, 0, 0, 1, 1, m);
        chk("r_pre_count", match_count, 3);
        #2 reset = 1'b1;
        #1;
        chk("r_busy", busy, 0);
        chk("r_count", match_count, 0);
        chk("r_ready", cfg_if.cfg_ready, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic, including aborts and reconfiguration.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 400; k++) begin
                setcfg(PAT_W'($urandom), LEN_W'($urandom), CNT_W'($urandom_range(5, 0)),
                       1'($urandom_range(1, 0)));
                cyc(($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0),
                    ($urandom_range(49, 0) == 0), ($urandom_range(2, 0) != 0),
                    1'($urandom_range(1, 0)), m);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run-time configurable serial pattern-detect controller. It accepts a pattern of up to PAT_W bits over a valid/ready configuration handshake and arms on `start`. It then scans a qualified serial bit stream, emitting a Mealy match pulse on the bit that completes the pattern, and counts matches until a programmed target count or an abort. It sits between the stimulus/serial front end and the status logic, and sequences the bit-level detector that the HDL lab designs drive directly.

## Interface
- PAT_W, 8, maximum pattern length in bits (2..8)
- LEN_W, 3, width of length code; must satisfy 2**LEN_W >= PAT_W
- CNT_W, 8, width of match counter and target
- TO_CYC, 64, idle-timeout cycles (used only with SEQDET_TIMEOUT_EN)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when high with cfg_valid; high only in IDLE
- cfg_pattern  in  PAT_W  pattern; bit L-1 oldest, bit 0 newest
- cfg_len  in  LEN_W  pattern length minus one (L = cfg_len+1)
- cfg_target  in  CNT_W  matches to reach before done; 0 = free-run
- cfg_overlap  in  1  1 = overlapping matches allowed
- start  in  1  arm request, sampled in IDLE
- abort  in  1  stop scanning, return to IDLE
- in_valid  in  1  in_bit qualified this cycle
- in_bit  in  1  serial data
- match  out  1  combinational Mealy pulse, pattern completed by current in_bit
- match_count  out  CNT_W  matches since last start
- busy  out  1  high in RUN
- done  out  1  one-cycle registered pulse on target reached
- timeout  out  1  one-cycle registered pulse on idle timeout; constant 0 without macro

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, history and fill cleared, config registers 0, match_count=0, cfg_ready=1, busy=0, done=0, timeout=0.
- IDLE: cfg_ready=1. cfg_valid latches pattern/len/target/overlap. If cfg handshake and start coincide, config is latched and start is ignored that cycle. start alone -> RUN; match_count and history cleared.
- RUN: each in_valid cycle shifts in_bit into history; fill counter saturates at PAT_W-1. Window = low L bits of {history, in_bit}. match = RUN & in_valid & ~abort & (fill >= L-1) & (window == pattern[L-1:0]).
- On match: match_count increments next edge (saturates at all-ones when target=0); overlap=0 clears history/fill so next match needs L fresh bits; overlap=1 keeps history.
- If target!=0 and match_count+1 == target on a match -> DONE. DONE lasts one cycle, done=1 there, then IDLE. match_count held until next start.
- abort in RUN -> IDLE next edge, no done, match suppressed, count held. abort outside RUN ignored.
- in_valid=0 cycles leave history untouched. Inputs in IDLE/DONE ignored.
- cfg_len values with L > PAT_W are clamped to PAT_W.

## Timing
- start sampled at edge n -> busy=1 from edge n; first bit consumed at edge n+1.
- match same cycle as completing bit (zero latency); match_count updates edge after.
- Final match at edge n -> state DONE, done=1 during cycle n..n+1, IDLE and cfg_ready=1 at edge n+1.
- Reset mid-RUN: immediate return to reset values; no done.

## Configuration
- SEQDET_TIMEOUT_EN defined: RUN keeps an idle counter cleared on in_valid; TO_CYC consecutive cycles with in_valid=0 -> IDLE, timeout pulses one cycle, count held, no done. abort takes priority over timeout.
- Undefined: no idle counter, timeout tied 0, RUN waits indefinitely.

## Test plan
- Pattern 2'b11, len=1, overlap=1, target=3, bits 0,1,1,1,0,1,1 -> match on bits 3,4,7; done one cycle after bit 7; match_count=3.
- Same stream, overlap=0 -> matches on bits 3,7 only; done not asserted; count=2; abort -> IDLE, count stays 2.
- Pattern 4'b1011, target=0, 200 random valid bits with in_valid gaps -> match count equals scoreboard count; no done.
- Abort and final match in same cycle -> match=0, count unchanged, IDLE next edge, done=0.
- cfg_valid+start same cycle in IDLE -> config taken, state stays IDLE; start next cycle -> RUN with new pattern.
- With SEQDET_TIMEOUT_EN, TO_CYC=16: start, hold in_valid=0 for 16 cycles -> timeout pulse, IDLE; 15 idle cycles then a bit -> no timeout.
